// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - single-channel TMDS receive decoder with symbol alignment
//
// Purpose:
//   Finds the 10-bit symbol boundary in an arbitrarily framed deserializer
//   stream by looking for runs of control tokens. Each aligned symbol is then
//   decoded into 8-bit video data or a 2-bit control token.
//
// Ports:
//   pixclk_i    pixel clock
//   rst_i       synchronous active-high reset
//   raw_i       deserialized word, bit 0 received first
//   locked_o    symbol alignment found
//   slip_pos_o  current rotation, 0..9
//   vd_o        decoded video data (valid when vde_o=1)
//   cd_o        decoded control data (valid when vde_o=0)
//   vde_o       video data enable
//   sym_err_o   one-cycle pulse on an illegal data symbol
//
// Configuration:
//   TMDS_DEC_ERRCHK_EN  when defined, builds the transition-count check,
//                       sym_err_o and the error-count unlock. When undefined,
//                       sym_err_o is 0 and only the watchdog drops lock.

module tmds_decoder #(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int ERR_LIMIT      = 4
) (
  input  logic       pixclk_i,
  input  logic       rst_i,
  input  logic [9:0] raw_i,
  output logic       locked_o,
  output logic [3:0] slip_pos_o,
  output logic [7:0] vd_o,
  output logic [1:0] cd_o,
  output logic       vde_o,
  output logic       sym_err_o
);

  localparam int TMR_W = $clog2(SEARCH_TIMEOUT);
  localparam int TOK_W = $clog2(LOCK_TOKENS + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(LOCK_TOKENS - 1);

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       raw_prev_q;
  logic [9:0]       w_q;
  logic [3:0]       slip_q, slip_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TOK_W-1:0] tok_q, tok_d;
  logic [7:0]       vd_q, vd_d;
  logic [1:0]       cd_q, cd_d;
  logic             vde_q, vde_d;
  logic             unlock_c;

  // Alignment: the previous word supplies the low half so that a symbol that
  // starts at bit slip_q of the older word is extracted intact.
  logic [19:0] cat;
  logic [9:0]  w_d;

  assign cat = {raw_i, raw_prev_q};
  assign w_d = cat[{1'b0, slip_q} +: 10];

  // Symbol decode of the aligned word
  logic       is_tok;
  logic [1:0] tok_cd;
  logic [7:0] q;
  logic [7:0] vd_dec;

  always_comb begin
    is_tok = 1'b1;
    tok_cd = 2'b00;
    case (w_q)
      TOK_00:  tok_cd = 2'b00;
      TOK_01:  tok_cd = 2'b01;
      TOK_10:  tok_cd = 2'b10;
      TOK_11:  tok_cd = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  always_comb begin
    q         = w_q[9] ? ~w_q[7:0] : w_q[7:0];
    vd_dec    = 8'h00;
    vd_dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      vd_dec[i] = w_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

`ifdef TMDS_DEC_ERRCHK_EN
  localparam int ERR_W = $clog2(ERR_LIMIT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);

  logic [ERR_W-1:0] err_q, err_d;
  logic             sym_err_q, sym_err_d;
  logic [2:0]       trans_cnt;
  logic             bad_sym;

  // A legal TMDS encoder never emits more than 4 transitions in q[7:0].
  always_comb begin
    trans_cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      trans_cnt = trans_cnt + {2'b00, q[i+1] ^ q[i]};
    end
    bad_sym = !is_tok && (trans_cnt > 3'd4);
  end
`endif

  // Alignment / lock FSM
  always_comb begin
    state_d  = state_q;
    slip_d   = slip_q;
    tmr_d    = tmr_q;
    tok_d    = tok_q;
    unlock_c = 1'b0;
`ifdef TMDS_DEC_ERRCHK_EN
    err_d     = err_q;
    sym_err_d = 1'b0;
`endif
    case (state_q)
      ST_SEARCH: begin
        tmr_d = tmr_q + TMR_W'(1);
        tok_d = is_tok ? tok_q + TOK_W'(1) : '0;
        if (is_tok && (tok_q == TOK_LAST)) begin
          state_d = ST_LOCKED;
          tmr_d   = '0;
          tok_d   = '0;
`ifdef TMDS_DEC_ERRCHK_EN
          err_d   = '0;
`endif
        end else if (tmr_q == TMR_LAST) begin
          slip_d = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
          tmr_d  = '0;
          tok_d  = '0;
        end
      end
      ST_LOCKED: begin
        tmr_d = is_tok ? '0 : tmr_q + TMR_W'(1);
        if (is_tok) begin
          if (tok_q == TOK_LAST) begin
            // A full token run proves the alignment is still good.
            tok_d = '0;
`ifdef TMDS_DEC_ERRCHK_EN
            err_d = '0;
`endif
          end else begin
            tok_d = tok_q + TOK_W'(1);
          end
        end else begin
          tok_d = '0;
        end
`ifdef TMDS_DEC_ERRCHK_EN
        if (bad_sym) begin
          sym_err_d = 1'b1;
          if (err_q != ERR_MAX) begin
            err_d = err_q + ERR_W'(1);
          end
        end
        if (err_d == ERR_MAX) begin
          unlock_c = 1'b1;
        end
`endif
        if (tmr_q == TMR_LAST) begin
          unlock_c = 1'b1;
        end
        if (unlock_c) begin
          state_d = ST_SEARCH;
          tmr_d   = '0;
          tok_d   = '0;
`ifdef TMDS_DEC_ERRCHK_EN
          err_d   = '0;
`endif
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Output gating follows the next state so that locked_o and the decoded
  // outputs change on the same edge.
  always_comb begin
    vd_d  = 8'h00;
    cd_d  = 2'b00;
    vde_d = 1'b0;
    if (state_d == ST_LOCKED) begin
      if (is_tok) begin
        cd_d = tok_cd;
      end else begin
        vde_d = 1'b1;
        vd_d  = vd_dec;
      end
    end
  end

  always_ff @(posedge pixclk_i) begin
    if (rst_i) begin
      state_q    <= ST_SEARCH;
      raw_prev_q <= '0;
      w_q        <= '0;
      slip_q     <= '0;
      tmr_q      <= '0;
      tok_q      <= '0;
      vd_q       <= '0;
      cd_q       <= '0;
      vde_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      raw_prev_q <= raw_i;
      w_q        <= w_d;
      slip_q     <= slip_d;
      tmr_q      <= tmr_d;
      tok_q      <= tok_d;
      vd_q       <= vd_d;
      cd_q       <= cd_d;
      vde_q      <= vde_d;
    end
  end

`ifdef TMDS_DEC_ERRCHK_EN
  // The error pulse belongs to a symbol judged while locked, so it is gated
  // by the current state; the symbol that forces unlock still reports.
  always_ff @(posedge pixclk_i) begin
    if (rst_i) begin
      err_q     <= '0;
      sym_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      sym_err_q <= sym_err_d;
    end
  end

  assign sym_err_o = sym_err_q;
`else
  assign sym_err_o = 1'b0;
`endif

  assign locked_o   = (state_q == ST_LOCKED);
  assign slip_pos_o = slip_q;
  assign vd_o       = vd_q;
  assign cd_o       = cd_q;
  assign vde_o      = vde_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - directed self-checking bench for tmds_decoder

module tb_tmds_decoder;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] D00  = 10'b0100000000; // -> 0x00
  localparam logic [9:0] DFF  = 10'b1000000000; // -> 0xFF (inverted path)
  localparam logic [9:0] D55  = 10'b0100110011; // -> 0x55 (XOR path)
  localparam logic [9:0] DERR = 10'b0001010101; // 7 transitions

  logic       pixclk = 1'b0;
  logic       rst    = 1'b1;
  logic [9:0] raw    = '0;
  logic       locked;
  logic [3:0] slip_pos;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       sym_err;

  int total = 0;
  int bad   = 0;

  always #5 pixclk = ~pixclk;

  tmds_decoder #(
    .LOCK_TOKENS   (8),
    .SEARCH_TIMEOUT(64),
    .ERR_LIMIT     (4)
  ) dut (
    .pixclk_i  (pixclk),
    .rst_i     (rst),
    .raw_i     (raw),
    .locked_o  (locked),
    .slip_pos_o(slip_pos),
    .vd_o      (vd),
    .cd_o      (cd),
    .vde_o     (vde),
    .sym_err_o (sym_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [9:0] r);
    raw = r;
    @(posedge pixclk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int n;
    logic [3:0] prev_slip;
    logic [9:0] sym;
    logic [9:0] prev_sym;
    logic [9:0] err_seq [7];
    logic [1:0] exp_cd [3];

    // Reset state
    rst = 1'b1;
    repeat (3) step(T00);
    chk("rst_locked", locked, 0);
    chk("rst_slip", slip_pos, 0);
    chk("rst_vd", vd, 0);
    chk("rst_cd", cd, 0);
    chk("rst_vde", vde, 0);
    chk("rst_sym_err", sym_err, 0);

    // Aligned lock: locked rises on the 10th edge after reset release
    rst = 1'b0;
    repeat (9) step(T00);
    chk("lock_edge9", locked, 0);
    step(T00);
    chk("lock_edge10", locked, 1);
    chk("lock_cd", cd, 0);
    chk("lock_vde", vde, 0);

    // Reset while locked, then relock
    rst = 1'b1;
    step(T00);
    chk("midrst_locked", locked, 0);
    chk("midrst_slip", slip_pos, 0);
    rst = 1'b0;
    repeat (10) step(T00);
    chk("relock1", locked, 1);

    // Data decode, two cycles of latency
    step(D00);
    step(DFF);
    step(D55);
    chk("dec00_vd", vd, 8'h00);
    chk("dec00_vde", vde, 1);
    step(T00);
    chk("decff_vd", vd, 8'hFF);
    chk("decff_vde", vde, 1);
    step(T00);
    chk("dec55_vd", vd, 8'h55);
    chk("dec55_vde", vde, 1);
    step(T00);
    chk("tok_vde", vde, 0);
    chk("tok_vd", vd, 0);

    // Control token values while locked
    exp_cd[0] = 2'b11;
    exp_cd[1] = 2'b01;
    exp_cd[2] = 2'b00;
    step(T11);
    step(T01);
    step(T00);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tok_cd%0d", i), cd, exp_cd[i]);
      step(T00);
    end
    repeat (8) step(T00);

    // Error symbols without an intervening token run
    err_seq = '{DERR, D00, DERR, D00, DERR, D00, DERR};
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(err_seq[i]);
      if (sym_err) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      step(T00);
      if (sym_err) pulses++;
    end
`ifdef TMDS_DEC_ERRCHK_EN
    chk("err_pulses", pulses, 4);
    chk("err_locked", locked, 0);
`else
    chk("err_pulses", pulses, 0);
    chk("err_locked", locked, 1);
`endif
    chk("err_slip", slip_pos, 0);
    repeat (12) step(T00);
    chk("relock2", locked, 1);

    // Watchdog: 64th data symbol processed drops lock
    repeat (65) step(D00);
    chk("wd_still_locked", locked, 1);
    chk("wd_vde", vde, 1);
    step(D00);
    chk("wd_locked", locked, 0);
    chk("wd_slip", slip_pos, 0);
    chk("wd_vde_off", vde, 0);

    // Slip stepping and wrap from 9 to 0
    for (int s = 1; s <= 10; s++) begin
      prev_slip = slip_pos;
      n = 0;
      while (slip_pos == prev_slip && n < 100) begin
        step(D00);
        n++;
      end
      chk($sformatf("slip_period%0d", s), n, 64);
      chk($sformatf("slip_val%0d", s), slip_pos, s % 10);
    end

    // Reset during search at slip 5
    n = 0;
    while (slip_pos != 4'd5 && n < 400) begin
      step(D00);
      n++;
    end
    chk("reach_slip5", slip_pos, 5);
    rst = 1'b1;
    step(D00);
    chk("rst5_slip", slip_pos, 0);
    chk("rst5_locked", locked, 0);
    rst = 1'b0;

    // Misaligned blanking stream, symbols delayed by 3 bits
    prev_sym = '0;
    n = 0;
    for (int k = 0; k < 500; k++) begin
      sym = ((k % 64) < 20) ? T01 : D00;
      step({sym[6:0], prev_sym[9:7]});
      prev_sym = sym;
      if (k == 62)  chk("mis_slip_e63", slip_pos, 0);
      if (k == 63)  chk("mis_slip_e64", slip_pos, 1);
      if (k == 127) chk("mis_slip_e128", slip_pos, 2);
      if (k == 191) chk("mis_slip_e192", slip_pos, 3);
      if (locked) begin
        n = k;
        break;
      end
    end
    chk("mis_locked", locked, 1);
    chk("mis_slip", slip_pos, 3);
    chk("mis_cd", cd, 2'b01);
    chk("mis_vde", vde, 0);
    chk("mis_lock_after_slip3", (n > 191) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
